// File: rtl/pixel_bus_initiator.sv
// pixel_bus_initiator: drives the pixel register-file bus for the CPU-side loader.
// Streams pixel words to FIRST_ADDR.., then writes the start word to address 0.
// Also issues single-word reads and returns the captured data.
// Optional build macro READBACK_VERIFY_EN: reads address 0 back after the start
// write and sets a sticky err flag on mismatch.
//
// Timing: every output is a flop. A state's bus action is computed while in that
// state and appears on the bus in the following cycle. Pixel writes follow each
// accepted in_valid/in_ready handshake by one cycle, so back-to-back transfers
// give one write per cycle.
module pixel_bus_initiator #(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 12,
  parameter int FIRST_ADDR      = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       go,
  input  logic [Amba_Addr_Depth:0]   frame_len,
  input  logic [Amba_Word-1:0]       start_word,
  input  logic                       in_valid,
  input  logic [Amba_Word-1:0]       in_data,
  output logic                       in_ready,
  input  logic                       rd_req,
  input  logic [Amba_Addr_Depth:0]   rd_addr,
  output logic [Amba_Word-1:0]       rd_data,
  output logic                       rd_valid,
  output logic [1:0]                 control,
  output logic [Amba_Addr_Depth:0]   address,
  output logic [Amba_Word-1:0]       WriteData,
  input  logic [Amba_Word-1:0]       ReadData,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int AW = Amba_Addr_Depth + 1;
  // Longest frame that fits between FIRST_ADDR and the top of the register file.
  localparam logic [AW-1:0] MAX_LEN = AW'((1 << Amba_Addr_Depth) - FIRST_ADDR);
  localparam logic [AW-1:0] BASE    = AW'(FIRST_ADDR);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, VRF_ISSUE, VRF_WAIT, DONE, RD_ISSUE, RD_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     len_q, len_d;
  logic [Amba_Word-1:0] start_q, start_d;
  logic [AW-1:0]     raddr_q, raddr_d;
  logic [1:0]        control_q, control_d;
  logic [AW-1:0]     address_q, address_d;
  logic [Amba_Word-1:0] wdata_q, wdata_d;
  logic              in_ready_q, in_ready_d;
  logic [Amba_Word-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              cap_q, cap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef READBACK_VERIFY_EN
  logic              vcap_q, vcap_d;
  logic              err_q, err_d;
`endif

  logic [AW-1:0] eff_len;
  assign eff_len = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      start_q    <= '0;
      raddr_q    <= '0;
      control_q  <= CMD_IDLE;
      address_q  <= '0;
      wdata_q    <= '0;
      in_ready_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      cap_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef READBACK_VERIFY_EN
      vcap_q     <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      start_q    <= start_d;
      raddr_q    <= raddr_d;
      control_q  <= control_d;
      address_q  <= address_d;
      wdata_q    <= wdata_d;
      in_ready_q <= in_ready_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      cap_q      <= cap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef READBACK_VERIFY_EN
      vcap_q     <= vcap_d;
      err_q      <= err_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    start_d    = start_q;
    raddr_d    = raddr_q;
    control_d  = CMD_IDLE;
    address_d  = address_q;
    wdata_d    = wdata_q;
    in_ready_d = in_ready_q;
    done_d     = 1'b0;
    cap_d      = 1'b0;
    // Read capture lands one cycle after RD_WAIT, when ReadData is valid.
    rd_valid_d = cap_q;
    rd_data_d  = cap_q ? ReadData : rd_data_q;
`ifdef READBACK_VERIFY_EN
    vcap_d     = 1'b0;
    err_d      = err_q | (vcap_q && (ReadData != start_q));
`endif
    case (state_q)
      IDLE: begin
        // busy_q still covers the trailing done / rd_valid cycles.
        if (!busy_q) begin
          if (go) begin
            len_d   = eff_len;
            start_d = start_word;
            cnt_d   = '0;
            if (eff_len == '0) begin
              state_d = START;
            end else begin
              state_d    = LOAD;
              in_ready_d = 1'b1;
            end
          end else if (rd_req) begin
            raddr_d = rd_addr;
            state_d = RD_ISSUE;
          end
        end
      end
      LOAD: begin
        if (in_valid && in_ready_q) begin
          control_d = CMD_WRITE;
          address_d = BASE + cnt_q;
          wdata_d   = in_data;
          cnt_d     = cnt_q + AW'(1);
          if ((cnt_q + AW'(1)) == len_q) begin
            in_ready_d = 1'b0;
            state_d    = START;
          end
        end
      end
      START: begin
        control_d = CMD_WRITE;
        address_d = '0;
        wdata_d   = start_q;
`ifdef READBACK_VERIFY_EN
        state_d   = VRF_ISSUE;
`else
        state_d   = DONE;
`endif
      end
      VRF_ISSUE: begin
        control_d = CMD_READ;
        address_d = '0;
        state_d   = VRF_WAIT;
      end
      VRF_WAIT: begin
`ifdef READBACK_VERIFY_EN
        vcap_d  = 1'b1;
`endif
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      RD_ISSUE: begin
        control_d = CMD_READ;
        address_d = raddr_q;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        cap_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // busy spans the state plus the lagging output cycle it produces.
    busy_d = (state_d != IDLE) || (state_q != IDLE);
  end

  assign control   = control_q;
  assign address   = address_q;
  assign WriteData = wdata_q;
  assign in_ready  = in_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef READBACK_VERIFY_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: doc/pixel_bus_initiator.md
Name: pixel_bus_initiator

Overview:
Bus-side initiator that drives the pixel register-file bus (control/address/WriteData/ReadData) on behalf of the CPU-side loader. It accepts a stream of packed pixel words over a valid/ready handshake and writes them to consecutive register addresses starting at FIRST_ADDR. It then writes the start word to address 0 to launch the recognizer. It also performs single-word reads on request and returns the captured data.

Parameters:
Amba_Word, 24, data word width (24 or 32)
Amba_Addr_Depth, 12, register-file address depth (12/13/14); address bus is Amba_Addr_Depth+1 bits
FIRST_ADDR, 1, address of the first pixel word; address 0 is reserved for the start word

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high reset
go  in  1  one-cycle pulse: begin a frame load (sampled in IDLE only)
frame_len  in  Amba_Addr_Depth+1  number of pixel words in the frame, latched on go
start_word  in  Amba_Word  value written to address 0 at frame end, latched on go
in_valid  in  1  pixel word available
in_data  in  Amba_Word  pixel word
in_ready  out  1  initiator accepts in_data this cycle
rd_req  in  1  one-cycle pulse: read one register (sampled in IDLE only)
rd_addr  in  Amba_Addr_Depth+1  read address, latched on rd_req
rd_data  out  Amba_Word  captured read data, held until next read
rd_valid  out  1  one-cycle pulse: rd_data updated
control  out  2  bus command: 00 idle, 01 write, 10 read
address  out  Amba_Addr_Depth+1  bus address
WriteData  out  Amba_Word  bus write data
ReadData  in  Amba_Word  bus read data; valid the cycle after control=10
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the start-word write
err  out  1  sticky readback-mismatch flag (see Optional Feature)

Behaviour:
- Reset (async, any state): state=IDLE; control=00; address=0; WriteData=0; in_ready=0; rd_data=0; rd_valid=0; busy=0; done=0; err=0; word counter=0. Any in-flight write or read is abandoned and no partial completion is signalled.
- All outputs are registered. control stays 00 in every cycle that is not an explicit write or read cycle.
- IDLE:
  - go=1: latch frame_len and start_word, clear counter, go to LOAD. If frame_len=0, go straight to START.
  - else rd_req=1: latch rd_addr, go to RD_ISSUE.
  - go and rd_req in the same cycle: go wins and rd_req is dropped.
- Clamp: if FIRST_ADDR+frame_len > 2**Amba_Addr_Depth, the effective length is 2**Amba_Addr_Depth-FIRST_ADDR. Addresses never wrap onto address 0.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid=1: control=01, address=FIRST_ADDR+count, WriteData=in_data; counter increments.
  - Cycles with in_valid=0: control=00, no counter change.
  - When the count reaches the effective length, in_ready drops on the following cycle and the state moves to START. No extra word is accepted.
  - Back-to-back transfers give one write per cycle.
- START: one cycle with control=01, address=0, WriteData=start_word. Next state is DONE.
- DONE: done=1 for one cycle, then IDLE. A go is accepted again one cycle after done.
- RD_ISSUE: one cycle with control=10, address=rd_addr. Next state is RD_WAIT.
- RD_WAIT: control=00; capture rd_data<=ReadData; rd_valid=1 on the following cycle; then IDLE. Read latency from the rd_req cycle to rd_valid is 3 clocks.
- busy=1 in LOAD, START, DONE, RD_ISSUE and RD_WAIT. go and rd_req while busy are ignored.
- The address MSB is driven 0 for all generated addresses below 2**Amba_Addr_Depth.

Optional Feature:
READBACK_VERIFY_EN
- Defined: after START, the FSM passes through VRF_ISSUE (control=10, address=0) and VRF_WAIT (compare ReadData to the latched start_word). A mismatch sets err, which stays set until reset. DONE follows VRF_WAIT, adding 2 cycles to frame completion. rd_valid is not pulsed for verify reads.
- Not defined: START goes directly to DONE and err is tied to 0.

Test Plan:
1. Reset then go with frame_len=3, start_word=0x000001, in_data 0xA1A1A1/0xB2B2B2/0xC3C3C3 back-to-back -> writes at addresses 1, 2, 3 on consecutive cycles, then address 0 written with 0x000001, one done pulse, busy low after.
2. Same frame with in_valid gapped (1,0,0,1,0,1) -> exactly 3 writes, control=00 in gap cycles, addresses 1..3 unchanged.
3. go with frame_len=0, start_word=0x0000FF -> no pixel writes, single write of 0x0000FF at address 0, done pulse.
4. frame_len=4096 with Amba_Addr_Depth=12 -> exactly 4095 writes (addresses 1..4095), no write to address 0 until START.
5. rd_req with rd_addr=5 against a model returning 0x123456 -> control=10 for one cycle, rd_data=0x123456, rd_valid 3 clocks after rd_req. go and rd_req in the same cycle -> load only. Async reset asserted mid-LOAD -> control=00 immediately and no done.
6. READBACK_VERIFY_EN defined, bus model corrupts address 0 readback -> err=1 after frame, stays set until reset. Correct model -> err=0 and done 2 cycles later than in test 1.
